// File: rtl/wavetable_sweep_ctrl.sv
// Frequency sweep sequencer feeding the wavetable freq port: steps a frequency word
// from start to stop with a programmable dwell after each accepted word, one-shot or looping.
module wavetable_sweep_ctrl #(
  parameter int DWIDTH      = 24,
  parameter int FRAC_BITS   = 9,
  parameter int DWELL_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [DWIDTH-1:0]      cfg_start_i,
  input  logic [DWIDTH-1:0]      cfg_stop_i,
  input  logic [DWIDTH-1:0]      cfg_step_i,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
  input  logic                   cfg_loop_i,
  output logic [DWIDTH-1:0]      freq_data_o,
  output logic                   freq_valid_o,
  input  logic                   freq_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  if (FRAC_BITS >= DWIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DWIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DWELL,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DWIDTH-1:0]      cur_q, cur_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   abort_pend_q, abort_pend_d;

  logic [DWIDTH-1:0]      start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   loop_q, single_q;
  logic                   load;

  logic [DWIDTH:0]        sum;
  logic [DWIDTH-1:0]      next_freq;
  logic                   handshake;

  // One bit of headroom so a carry out of the add clamps to stop instead of wrapping.
  assign sum       = {1'b0, cur_q} + {1'b0, step_q};
  assign next_freq = (sum > {1'b0, stop_q}) ? stop_q : sum[DWIDTH-1:0];
  assign handshake = (state_q == S_EMIT) && freq_ready_i;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    abort_pend_d = abort_pend_q;
    load         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          load         = 1'b1;
          cur_d        = cfg_start_i;
          abort_pend_d = 1'b0;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (handshake) begin
          if (abort_i || abort_pend_q) begin
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            cnt_d   = dwell_q;
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (single_q || (cur_q == stop_q)) begin
          // Degenerate sweeps never loop: they would just repeat the start word forever.
          if (loop_q && !single_q) begin
            cur_d   = start_q;
            state_d = S_EMIT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cur_d   = next_freq;
          state_d = S_EMIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      single_q <= 1'b0;
    end else if (load) begin
      start_q  <= cfg_start_i;
      stop_q   <= cfg_stop_i;
      step_q   <= cfg_step_i;
      dwell_q  <= cfg_dwell_i;
      loop_q   <= cfg_loop_i;
      single_q <= (cfg_step_i == '0) || (cfg_start_i >= cfg_stop_i);
    end
  end

  // cur only changes on the way into EMIT, so outside EMIT it is the last word sent.
  assign freq_data_o  = cur_q;
  assign freq_valid_o = (state_q == S_EMIT);
  assign busy_o       = (state_q == S_EMIT) || (state_q == S_DWELL);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_wavetable_sweep_ctrl.sv
// Directed bench for wavetable_sweep_ctrl: records every freq handshake and done pulse
// and compares word sequences, spacing and control outputs against hand-computed values.
module tb_wavetable_sweep_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [23:0] cfg_start, cfg_stop, cfg_step;
  logic [31:0] cfg_dwell;
  logic        cfg_loop;
  logic [23:0] freq_data;
  logic        freq_valid;
  logic        freq_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [31:0] hs_data[$];
  int          hs_cyc[$];
  logic [31:0] exp_w[$];

  wavetable_sweep_ctrl #(.DWIDTH(24), .FRAC_BITS(9), .DWELL_WIDTH(32)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_start_i  (cfg_start),
    .cfg_stop_i   (cfg_stop),
    .cfg_step_i   (cfg_step),
    .cfg_dwell_i  (cfg_dwell),
    .cfg_loop_i   (cfg_loop),
    .freq_data_o  (freq_data),
    .freq_valid_o (freq_valid),
    .freq_ready_i (freq_ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so at negedge valid&ready marks the next edge's handshake.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (freq_valid && freq_ready) begin
      hs_data.push_back({8'h00, freq_data});
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic run(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                     input logic [31:0] dw, input logic lp);
    cfg_start = s;
    cfg_stop  = e;
    cfg_step  = st;
    cfg_dwell = dw;
    cfg_loop  = lp;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic check_run(input string tag, input int gap, input int exp_done);
    chk({tag, "_nwords"}, hs_data.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), hs_data[i], exp_w[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), hs_cyc[i] - hs_cyc[i-1], gap);
    end
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_start  = '0;
    cfg_stop   = '0;
    cfg_step   = '0;
    cfg_dwell  = '0;
    cfg_loop   = 1'b0;
    freq_ready = 1'b1;
    tick(3);
    chk("rst_valid", freq_valid, 0);
    chk("rst_data", freq_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick(2);

    // Up-sweep, dwell 3 -> one word every 5 cycles, done 5 cycles after last handshake.
    clear_log();
    run(24'd512, 24'd2560, 24'd512, 32'd3, 1'b0);
    chk("up_first_valid", freq_valid, 1);
    chk("up_first_busy", busy, 1);
    tick(40);
    exp_w = {32'd512, 32'd1024, 32'd1536, 32'd2048, 32'd2560};
    check_run("up", 5, 1);
    chk("up_done_lag", done_cyc - hs_cyc[4], 5);
    chk("up_busy_end", busy, 0);
    chk("up_hold_data", freq_data, 2560);
    chk("up_valid_end", freq_valid, 0);

    // Last step clamps to stop.
    clear_log();
    run(24'd512, 24'd1800, 24'd512, 32'd0, 1'b0);
    tick(20);
    exp_w = {32'd512, 32'd1024, 32'd1536, 32'd1800};
    check_run("sat", 2, 1);

    // Carry out of the top bit must clamp, not wrap.
    clear_log();
    run(24'hFFFE00, 24'hFFFFFF, 24'h000400, 32'd0, 1'b0);
    tick(10);
    exp_w = {32'h00FFFE00, 32'h00FFFFFF};
    check_run("carry", 2, 1);

    // Backpressure for 7 cycles; a cfg_stop change mid-sweep is ignored.
    clear_log();
    freq_ready = 1'b0;
    run(24'd512, 24'd1536, 24'd512, 32'd2, 1'b0);
    cfg_stop = 24'd512;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_valid%0d", i), freq_valid, 1);
      chk($sformatf("bp_data%0d", i), freq_data, 512);
      tick(1);
    end
    freq_ready = 1'b1;
    tick(20);
    exp_w = {32'd512, 32'd1024, 32'd1536};
    check_run("bp", 4, 1);

    // Looping sweep runs until aborted, never pulses done.
    clear_log();
    run(24'd512, 24'd1024, 24'd512, 32'd1, 1'b1);
    tick(20);
    chk("loop_busy", busy, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(3);
    chk("loop_busy_after_abort", busy, 0);
    chk("loop_done_cnt", done_cnt, 0);
    chk("loop_w0", hs_data[0], 512);
    chk("loop_w1", hs_data[1], 1024);
    chk("loop_w2", hs_data[2], 512);
    chk("loop_w3", hs_data[3], 1024);
    chk("loop_gap", hs_cyc[1] - hs_cyc[0], 3);

    // Degenerate sweeps emit the start word once then finish, even with loop set.
    clear_log();
    run(24'd512, 24'd1024, 24'd0, 32'd0, 1'b1);
    tick(10);
    exp_w = {32'd512};
    check_run("step0", 2, 1);
    clear_log();
    run(24'd2048, 24'd1024, 24'd512, 32'd0, 1'b1);
    tick(10);
    exp_w = {32'd2048};
    check_run("rev", 2, 1);

    // Abort during DWELL -> IDLE on the next cycle.
    clear_log();
    run(24'd512, 24'd2560, 24'd512, 32'd5, 1'b0);
    tick(1);
    chk("abd_in_dwell", {busy, freq_valid}, 2'b10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abd_busy", busy, 0);
    tick(10);
    chk("abd_done_cnt", done_cnt, 0);
    chk("abd_nwords", hs_data.size(), 1);

    // Abort pulse during a stalled EMIT: valid holds until the handshake, then IDLE.
    clear_log();
    freq_ready = 1'b0;
    run(24'd512, 24'd2560, 24'd512, 32'd0, 1'b0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abe_valid%0d", i), freq_valid, 1);
      tick(1);
    end
    freq_ready = 1'b1;
    tick(1);
    chk("abe_busy", busy, 0);
    chk("abe_valid_end", freq_valid, 0);
    tick(5);
    chk("abe_nwords", hs_data.size(), 1);
    chk("abe_done_cnt", done_cnt, 0);
    chk("abe_data_hold", freq_data, 512);

    // Start together with abort in IDLE does nothing.
    clear_log();
    abort = 1'b1;
    run(24'd512, 24'd1024, 24'd512, 32'd0, 1'b0);
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_valid", freq_valid, 0);
    tick(5);
    chk("sa_nwords", hs_data.size(), 0);

    // Reset during EMIT drops the sweep; a later start runs normally.
    clear_log();
    freq_ready = 1'b0;
    run(24'd1536, 24'd2560, 24'd512, 32'd0, 1'b0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("rm_valid", freq_valid, 0);
    chk("rm_data", freq_data, 0);
    chk("rm_busy", busy, 0);
    freq_ready = 1'b1;
    tick(3);
    chk("rm_done_cnt", done_cnt, 0);
    clear_log();
    run(24'd512, 24'd1024, 24'd512, 32'd0, 1'b0);
    tick(10);
    exp_w = {32'd512, 32'd1024};
    check_run("rm_after", 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wavetable_sweep_ctrl.md
WAVETABLE_SWEEP_CTRL -- requirements
Module: wavetable_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 24: frequency word width, unsigned fixed point matching the wavetable freq input.
REQ-002 SHALL have parameter FRAC_BITS, default 9: fractional bits of the frequency word, so 1 Hz = 512.
REQ-003 SHALL have parameter DWELL_WIDTH, default 32: width of the dwell counter.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 abort  input  1  request to terminate the sweep.
REQ-008 cfg_start  input  DWIDTH  first frequency of the sweep.
REQ-009 cfg_stop  input  DWIDTH  final frequency of the sweep.
REQ-010 cfg_step  input  DWIDTH  frequency increment per step.
REQ-011 cfg_dwell  input  DWELL_WIDTH  extra hold cycles after each accepted word.
REQ-012 cfg_loop  input  1  0 = one-shot, 1 = restart at cfg_start after reaching cfg_stop.
REQ-013 freq  Axis_If master  DWIDTH  freq.data, freq.valid (out), freq.ready (in); feeds the wavetable freq port.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-016 SHALL implement states IDLE, EMIT, DWELL, DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL latch all cfg_* into shadow registers, load cur=cfg_start, and enter EMIT; cfg_* changes after that cycle SHALL have no effect until the next start.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 In EMIT, freq.valid SHALL be 1 and freq.data=cur, with freq.data held stable until the handshake (valid&ready).
REQ-020 On the handshake in EMIT at cycle N, the block SHALL enter DWELL with counter=cfg_dwell.
REQ-021 In DWELL, the counter SHALL decrement while non-zero; at zero, the block SHALL leave DWELL, so the next freq.valid rises at cycle N+cfg_dwell+2.
REQ-022 On leaving DWELL with cur != cfg_stop, cur SHALL become min(cur+cfg_step, cfg_stop), computed at DWIDTH+1 bits so that carry-out saturates to cfg_stop, and the block SHALL return to EMIT.
REQ-023 On leaving DWELL with cur == cfg_stop, the block SHALL go to DONE if cfg_loop=0, or set cur=cfg_start and go to EMIT if cfg_loop=1.
REQ-024 A sweep with cfg_step=0 or cfg_start>=cfg_stop SHALL emit cfg_start exactly once and then terminate per REQ-023; with cfg_loop=1 it SHALL terminate to DONE, never repeating.
REQ-025 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-026 busy SHALL be 1 in EMIT and DWELL and 0 in IDLE and DONE.
REQ-027 Outside EMIT, freq.valid SHALL be 0 and freq.data SHALL hold the last emitted value.
REQ-028 abort in DWELL SHALL go to IDLE on the next cycle, with no done pulse.
REQ-029 abort in EMIT SHALL set a sticky abort_pending flag; freq.valid SHALL stay 1 until the handshake, after which the block SHALL go to IDLE instead of DWELL and clear the flag.
REQ-030 abort and start in the same IDLE cycle SHALL leave the block in IDLE.

Reset
REQ-031 While reset_n=0 at a rising edge: state=IDLE, cur=0, freq.data=0, freq.valid=0, busy=0, done=0, abort_pending=0, counter=0.
REQ-032 reset_n=0 mid-sweep SHALL abandon the sweep with no done pulse; any in-flight freq.valid SHALL drop on that edge.

Verification
REQ-033 Up-sweep: start=512, stop=2560, step=512, dwell=3, loop=0, ready=1 -> words 512, 1024, 1536, 2048, 2560, valid rising every 5 cycles; done pulses 5 cycles after the 2560 handshake; busy then low.
REQ-034 Saturating last step: start=512, stop=1800, step=512, dwell=0 -> words 512, 1024, 1536, 1800, 2 cycles apart; also start=0xFFFE00, step=0x000400, stop=0xFFFFFF -> 0xFFFE00, 0xFFFFFF with no wrap.
REQ-035 Backpressure: ready held 0 for 7 cycles during the first EMIT -> freq.data stays 512 with valid=1; after the handshake, the dwell timing of REQ-021 is preserved; a cfg_stop change mid-sweep has no effect.
REQ-036 Loop: loop=1, start=512, stop=1024, step=512, dwell=1 -> 512, 1024, 512, 1024, ... with no done pulse; step=0 with loop=1 -> a single 512 word, then done.
REQ-037 Abort: abort in DWELL -> IDLE next cycle, done=0; abort pulse while EMIT with ready=0 for 4 cycles -> valid stays 1, then IDLE after the handshake; start and abort together in IDLE -> stays IDLE.
REQ-038 Reset mid-operation: reset_n=0 for 1 cycle during EMIT -> freq.valid=0, freq.data=0, busy=0 next cycle; a subsequent start runs normally.
